fc_seq_ctrl: RTL and testbench

- Sequencer for a fully-connected layer built from NUM_PE parallel 8-bit MAC processing elements.
- Each PE has a 32-bit accumulator with clear and enable controls.
- The block processes output neurons in groups of NUM_PE. For each group it clears the accumulators, streams in_len pixel/weight reads, and waits one cycle for the last MAC to land. It then drains the group's results serially over a valid/ready stream.
- It sits between the layer-level controller (start/config) and the activation/weight SRAMs plus the PE array.

---
 rtl/fc_seq_ctrl.sv | 104 ++++++++++
 tb/tb_fc_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: group-wise sequencer for a fully-connected layer on NUM_PE MAC elements.
module fc_seq_ctrl #(
  parameter int NUM_PE    = 8,
  parameter int IN_LEN_W  = 10,
  parameter int OUT_NUM_W = 8,
  parameter int WADDR_W   = 14
) (
  input  logic                    clk_i,
  input  logic                    rst_async_n_i,
  input  logic                    start_i,
  input  logic [IN_LEN_W-1:0]     in_len_i,
  input  logic [OUT_NUM_W-1:0]    out_num_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pix_rd_en_o,
  output logic [IN_LEN_W-1:0]     pix_addr_o,
  output logic                    wgt_rd_en_o,
  output logic [WADDR_W-1:0]      wgt_addr_o,
  output logic                    pe_clear_o,
  output logic                    pe_enable_o,
  input  logic [NUM_PE*32-1:0]    pe_result_i,
  output logic                    res_valid_o,
  output logic [31:0]             res_data_o,
  output logic [OUT_NUM_W-1:0]    res_idx_o,
  input  logic                    res_ready_i
);
  localparam int DW = $clog2(NUM_PE);
  localparam int NW = OUT_NUM_W + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, FLUSH, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IN_LEN_W-1:0]  in_len_q, k_q;
  logic [OUT_NUM_W-1:0] out_num_q;
  logic [NW-1:0]        nb_q, nb_nxt, rem;
  logic [DW-1:0]        d_q;
  logic [WADDR_W-1:0]   gbase_q;
  logic                 k_last, d_last, hs;

  // nb is one bit wider than out_num so the final group's increment cannot wrap
  assign k_last = k_q == in_len_q - IN_LEN_W'(1);
  assign rem    = {1'b0, out_num_q} - nb_q;
  assign nb_nxt = nb_q + NW'(NUM_PE);
  assign d_last = (d_q == DW'(NUM_PE - 1)) || (NW'(d_q) + NW'(1) == rem);
  assign hs     = (state_q == DRAIN) && res_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (out_num_i == '0) ? DONE : CLEAR;
      CLEAR:   state_d = (in_len_q != '0) ? MAC : FLUSH;
      MAC:     if (k_last) state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (hs && d_last) state_d = (nb_nxt >= {1'b0, out_num_q}) ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state_q     <= IDLE;
      pe_enable_o <= 1'b0;
      in_len_q    <= '0;
      out_num_q   <= '0;
      k_q         <= '0;
      nb_q        <= '0;
      d_q         <= '0;
      gbase_q     <= '0;
    end else begin
      state_q     <= state_d;
      pe_enable_o <= pix_rd_en_o;
      if (state_q == IDLE && start_i) begin
        in_len_q  <= in_len_i;
        out_num_q <= out_num_i;
        k_q       <= '0;
        nb_q      <= '0;
        d_q       <= '0;
        gbase_q   <= '0;
      end
      if (state_q == MAC) k_q <= k_last ? '0 : k_q + IN_LEN_W'(1);
      if (state_q == FLUSH) d_q <= '0;
      if (hs) begin
        d_q <= d_q + DW'(1);
        if (d_last) begin
          nb_q    <= nb_nxt;
          gbase_q <= gbase_q + WADDR_W'(in_len_q);
        end
      end
    end
  end

  // outputs are gated to zero outside their active state so reset drives everything low
  assign busy_o      = state_q != IDLE;
  assign done_o      = state_q == DONE;
  assign pix_rd_en_o = state_q == MAC;
  assign wgt_rd_en_o = state_q == MAC;
  assign pix_addr_o  = pix_rd_en_o ? k_q : '0;
  assign wgt_addr_o  = wgt_rd_en_o ? gbase_q + WADDR_W'(k_q) : '0;
  assign pe_clear_o  = state_q == CLEAR;
  assign res_valid_o = state_q == DRAIN;
  assign res_data_o  = res_valid_o ? pe_result_i[32*d_q +: 32] : '0;
  assign res_idx_o   = res_valid_o ? nb_q[OUT_NUM_W-1:0] + OUT_NUM_W'(d_q) : '0;
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb_fc_seq_ctrl: randomized bench with behavioural SRAM/PE environment and a result scoreboard.
module tb_fc_seq_ctrl;
  localparam int NP = 8;

  logic              clk_i = 1'b0;
  logic              rst_async_n_i = 1'b0;
  logic              start_i = 1'b0;
  logic [9:0]        in_len_i = '0;
  logic [7:0]        out_num_i = '0;
  logic              busy_o, done_o, pix_rd_en_o, wgt_rd_en_o, pe_clear_o, pe_enable_o;
  logic [9:0]        pix_addr_o;
  logic [13:0]       wgt_addr_o;
  logic [NP*32-1:0]  pe_result_i;
  logic              res_valid_o;
  logic [31:0]       res_data_o;
  logic [7:0]        res_idx_o;
  logic              res_ready_i = 1'b0;

  fc_seq_ctrl dut (
    .clk_i(clk_i), .rst_async_n_i(rst_async_n_i), .start_i(start_i),
    .in_len_i(in_len_i), .out_num_i(out_num_i), .busy_o(busy_o), .done_o(done_o),
    .pix_rd_en_o(pix_rd_en_o), .pix_addr_o(pix_addr_o), .wgt_rd_en_o(wgt_rd_en_o),
    .wgt_addr_o(wgt_addr_o), .pe_clear_o(pe_clear_o), .pe_enable_o(pe_enable_o),
    .pe_result_i(pe_result_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_idx_o(res_idx_o), .res_ready_i(res_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int in_len_m = 0, out_num_m = 0;
  bit wones = 0;
  logic [7:0]  pix_mem [1024];
  logic [31:0] got_data [64];
  int rq_pix [$];
  int rq_wgt [$];
  int next_idx, clears, first_valid, done_cyc;
  bit done_seen, prev_stall;
  logic [31:0] prev_data;
  logic [7:0]  prev_idx;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] wfn(input int addr, input int p);
    return wones ? 8'd1 : 8'((addr * 37 + p * 11 + 5) ^ (addr >> 2));
  endfunction

  // neuron n lives in group n/NP, PE n%NP, weight words starting at group*in_len
  function automatic logic [31:0] exp_val(input int n);
    int g;
    int p;
    logic [31:0] s;
    g = n / NP;
    p = n % NP;
    s = '0;
    for (int k = 0; k < in_len_m; k++) s += 32'(pix_mem[k]) * 32'(wfn(g * in_len_m + k, p));
    return s;
  endfunction

  logic [7:0]  pix_q;
  logic [7:0]  wgt_q [NP];
  logic [31:0] acc [NP];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (pix_rd_en_o) pix_q <= pix_mem[pix_addr_o];
    for (int p = 0; p < NP; p++) begin
      if (wgt_rd_en_o) wgt_q[p] <= wfn(int'(wgt_addr_o), p);
      if (pe_clear_o) acc[p] <= '0;
      else if (pe_enable_o) acc[p] <= acc[p] + 32'(pix_q) * 32'(wgt_q[p]);
    end
  end

  always_comb begin
    pe_result_i = '0;
    for (int p = 0; p < NP; p++) pe_result_i[32*p +: 32] = acc[p];
  end

  initial forever begin
    @(negedge clk_i);
    if (rst_async_n_i) begin
      if (pix_rd_en_o || wgt_rd_en_o) begin
        if (rq_pix.size() == 0) chk("unexpected_read", 64'(pix_rd_en_o | wgt_rd_en_o), 0);
        else begin
          chk("rd_en_pair", 64'(wgt_rd_en_o), 64'(pix_rd_en_o));
          chk("pix_addr", 64'(pix_addr_o), 64'(rq_pix.pop_front()));
          chk("wgt_addr", 64'(wgt_addr_o), 64'(rq_wgt.pop_front()));
        end
      end
      if (pe_clear_o) clears++;
      if (prev_stall && res_valid_o) begin
        chk("stall_data", 64'(res_data_o), 64'(prev_data));
        chk("stall_idx", 64'(res_idx_o), 64'(prev_idx));
      end
      prev_stall = res_valid_o && !res_ready_i;
      prev_data = res_data_o;
      prev_idx = res_idx_o;
      if (res_valid_o && first_valid < 0) first_valid = cyc - start_cyc;
      if (res_valid_o && res_ready_i) begin
        if (next_idx >= out_num_m) chk("extra_result", 64'(res_valid_o), 0);
        else begin
          chk("res_idx", 64'(res_idx_o), 64'(next_idx));
          chk("res_data", 64'(res_data_o), 64'(exp_val(next_idx)));
          got_data[next_idx] = res_data_o;
          next_idx++;
        end
      end
      if (done_o) begin
        chk("done_count", 64'(next_idx), 64'(out_num_m));
        chk("done_busy", 64'(busy_o), 1);
        if (done_seen) chk("double_done", 64'(done_o), 0);
        done_seen = 1;
        done_cyc = cyc - start_cyc;
      end
    end
  end

  task automatic run_job(input int il, input int on, input int rmode, input bit pulse,
                         input bit ones, input bit abort);
    bit pulsed;
    pulsed = 0;
    in_len_m = il;
    out_num_m = on;
    wones = ones;
    for (int k = 0; k < 1024; k++) pix_mem[k] = ones ? 8'(k + 1) : 8'($urandom);
    rq_pix.delete();
    rq_wgt.delete();
    for (int g = 0; g < (on + NP - 1) / NP; g++)
      for (int k = 0; k < il; k++) begin
        rq_pix.push_back(k);
        rq_wgt.push_back(g * il + k);
      end
    next_idx = 0; clears = 0; first_valid = -1; done_cyc = -1;
    done_seen = 0; prev_stall = 0;
    @(posedge clk_i); #1;
    start_i = 1; in_len_i = 10'(il); out_num_i = 8'(on);
    res_ready_i = (rmode != 1);
    start_cyc = cyc;
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      @(posedge clk_i); #1;
      start_i = 0;
      in_len_i = 10'($urandom);
      out_num_i = 8'($urandom);
      res_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~res_ready_i : 1'($urandom_range(0, 1));
      if (pulse && !pulsed && pix_rd_en_o) begin
        start_i = 1;
        pulsed = 1;
      end
      if (abort && res_valid_o && next_idx >= 3) begin
        rst_async_n_i = 0;
        #1;
        chk("abort_zero", {busy_o, done_o, pix_rd_en_o, pix_addr_o, wgt_rd_en_o, wgt_addr_o,
                           pe_clear_o, pe_enable_o, res_valid_o, res_data_o, res_idx_o}, 0);
        chk("abort_no_done", 64'(done_seen), 0);
        break;
      end
    end
    start_i = 0;
    if (abort) begin
      repeat (3) @(posedge clk_i);
      #1;
      rst_async_n_i = 1;
      rq_pix.delete();
      rq_wgt.delete();
      return;
    end
    if (!done_seen) chk("timeout", 64'(done_seen), 1);
    if (pulse) chk("pulse_applied", 64'(pulsed), 1);
    chk("reads_left", 64'(rq_pix.size()), 0);
    chk("result_count", 64'(next_idx), 64'(on));
    chk("clear_count", 64'(clears), 64'((on + NP - 1) / NP));
    chk("idle_busy", 64'(busy_o), 0);
    if (rmode == 0 && on > 0 && on <= NP) begin
      chk("first_valid_lat", 64'(first_valid), 64'(il + 3));
      chk("done_lat", 64'(done_cyc), 64'(il + 3 + on));
    end
    if (on == 0) begin
      chk("no_results", 64'(first_valid), 64'(-1));
      chk("done_lat0", 64'(done_cyc >= 1 && done_cyc <= 2), 1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_zero", {busy_o, done_o, pix_rd_en_o, pix_addr_o, wgt_rd_en_o, wgt_addr_o,
                       pe_clear_o, pe_enable_o, res_valid_o, res_data_o, res_idx_o}, 0);
    rst_async_n_i = 1;
    run_job(4, 8, 0, 0, 1, 0);
    chk("t1_first_valid", 64'(first_valid), 7);
    chk("t1_done", 64'(done_cyc), 15);
    for (int n = 0; n < 8; n++) chk("t1_data", 64'(got_data[n]), 10);
    run_job(3, 11, 0, 0, 0, 0);
    chk("t2_clears", 64'(clears), 2);
    run_job(4, 20, 1, 0, 0, 0);
    run_job(0, 5, 0, 0, 0, 0);
    for (int n = 0; n < 5; n++) chk("t4_zero", 64'(got_data[n]), 0);
    run_job(0, 0, 0, 0, 0, 0);
    run_job(6, 10, 0, 1, 0, 0);
    run_job(5, 16, 0, 0, 0, 1);
    chk("post_abort_idle", 64'(busy_o), 0);
    run_job(5, 9, 0, 0, 0, 0);
    for (int j = 0; j < 12; j++)
      run_job($urandom_range(0, 20), $urandom_range(0, 40), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
